soc_io: RTL
===========

SOC_IO -- requirements
Module: soc_io

Interface
REQ-001 Parameter CLK_HZ, default 27000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART transmit bit rate.
REQ-003 Parameter LED_W, default 6, LED register width, legal range 1..32.
REQ-004 Parameter IO_BIT, default 22, mem_addr bit that selects IO space when 1.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 mem_addr  in  32  CPU byte address.
REQ-008 mem_wdata  in  32  CPU write data.
REQ-009 mem_wmask  in  4  byte-lane write enables; any bit set means a write.
REQ-010 mem_ren  in  1  CPU read strobe.
REQ-011 io_sel  out  1  combinational copy of mem_addr[IO_BIT], used by the parent to mux io_rdata against RAM data.
REQ-012 io_rdata  out  32  registered IO read data.
REQ-013 leds  out  LED_W  LED register contents.
REQ-014 txd  out  1  UART serial output, idle high.
REQ-015 uart_busy  out  1  high while a UART frame is in progress.

Function
REQ-016 Register select SHALL be mem_addr[4:2]: 0 = LEDS (read/write), 1 = UART_DATA (write-only), 2 = UART_STATUS (read-only, bit0 = busy), all other values unmapped.
REQ-017 An IO write SHALL occur on a clock edge where io_sel=1 and mem_wmask!=0; accesses with io_sel=0 SHALL have no effect on any state.
REQ-018 An LEDS write SHALL update only the bits in byte lanes enabled by mem_wmask, truncated to LED_W; leds SHALL reflect the new value on the cycle after the write edge.
REQ-019 On an edge with io_sel=1 and mem_ren=1, io_rdata SHALL load the selected register, zero-extended to 32 bits, giving one-cycle read latency. Unmapped and UART_DATA offsets SHALL read 0. Otherwise io_rdata holds its value.
REQ-020 The bit period SHALL be DIV = CLK_HZ/BAUD clock cycles, integer truncation, with DIV>=2 required.
REQ-021 The UART FSM SHALL have states IDLE, START, DATA and STOP.
REQ-022 In IDLE, a UART_DATA write with mem_wmask[0]=1 SHALL latch mem_wdata[7:0], enter START, and raise uart_busy on the next cycle.
REQ-023 START SHALL drive txd=0 for DIV cycles, then go to DATA.
REQ-024 DATA SHALL shift out 8 bits LSB first, each for DIV cycles, using a 3-bit bit counter, then go to STOP.
REQ-025 STOP SHALL drive txd=1 for DIV cycles, then go to IDLE with uart_busy=0; a frame is exactly 10*DIV cycles.
REQ-026 A UART_DATA write while uart_busy=1 SHALL be dropped, including a write on the final STOP cycle; the current frame SHALL be unaffected.
REQ-027 A same-cycle read of UART_STATUS and a write of UART_DATA SHALL return the pre-write busy value.
REQ-028 The divider counter SHALL reset to 0 at every bit boundary, so no cycles accumulate across bits.

Reset
REQ-029 While rst_n=0: leds=0, io_rdata=0, txd=1, uart_busy=0, FSM=IDLE, counters=0, regardless of clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no partial stop bit.
REQ-031 After release, the block SHALL accept a write on the first clock edge.

Verification (CLK_HZ=1000, BAUD=100, so DIV=10; LED_W=6; IO_BIT=22)
REQ-032 Reset: assert rst_n=0 -> leds=0, txd=1, uart_busy=0, io_rdata=0.
REQ-033 LEDS: write 0x2A, mask 0001, at 0x00400000 -> leds=6'b101010 next cycle; read of the same address -> io_rdata=0x2A one cycle later.
REQ-034 Frame: write 0x55 to 0x00400004 -> txd low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles; uart_busy=1 for exactly 100 cycles; STATUS read mid-frame = 1.
REQ-035 Overrun: write 0xFF at frame cycle 50 and again on the final STOP cycle -> both dropped, waveform identical to REQ-034, txd idle afterwards.
REQ-036 Mid-frame reset: assert rst_n=0 at frame cycle 35 -> txd=1 and uart_busy=0 immediately; a new write after release produces a full clean frame.
REQ-037 Decode: write 0x3F, mask 1111, to 0x00000000 (io_sel=0) -> leds unchanged; write to offset 7 -> no state change, reads 0.

Source files
------------

// File: rtl/soc_io.sv
// SoC IO block: memory-mapped LED register, UART transmitter and status register.
module soc_io #(
  parameter int unsigned CLK_HZ = 27000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned LED_W  = 6,
  parameter int unsigned IO_BIT = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic             mem_ren,
  output logic             io_sel,
  output logic [31:0]      io_rdata,
  output logic [LED_W-1:0] leds,
  output logic             txd,
  output logic             uart_busy
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;

  logic [2:0]  sel;
  logic        io_wr;
  logic        uart_wr;
  logic        bit_end;
  logic [31:0] lane_mask;
  logic [31:0] leds_ext;
  logic [31:0] leds_new;

  assign io_sel    = mem_addr[IO_BIT];
  assign sel       = mem_addr[4:2];
  assign io_wr     = io_sel && (mem_wmask != 4'b0000);
  assign uart_wr   = io_wr && (sel == REG_UART_DATA) && mem_wmask[0];
  assign bit_end   = (cnt == CW'(DIV - 1));
  assign lane_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                      {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
  assign leds_ext  = 32'(leds);
  assign leds_new  = (leds_ext & ~lane_mask) | (mem_wdata & lane_mask);

  // LED register: byte-lane masked write, truncated to LED_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
    end else if (io_wr && (sel == REG_LEDS)) begin
      leds <= leds_new[LED_W-1:0];
    end
  end

  // Read data register: one-cycle latency; status reflects busy before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
    end else if (io_sel && mem_ren) begin
      case (sel)
        REG_LEDS:        io_rdata <= leds_ext;
        REG_UART_STATUS: io_rdata <= {31'b0, uart_busy};
        default:         io_rdata <= '0;
      endcase
    end
  end

  // UART state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
    end
  end

  // UART next-state: divider restarts at every bit boundary; writes only accepted in IDLE.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    if (state == IDLE) begin
      cnt_nx     = '0;
      bit_cnt_nx = '0;
      if (uart_wr) begin
        shift_nx = mem_wdata[7:0];
        state_nx = START;
      end
    end else begin
      cnt_nx = bit_end ? '0 : cnt + CW'(1);
      case (state)
        START: if (bit_end) state_nx = DATA;
        DATA: begin
          if (bit_end) begin
            shift_nx   = {1'b0, shift[7:1]};
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nx = STOP;
          end
        end
        STOP:    if (bit_end) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Line driver and busy flag decoded directly from the state register.
  always_comb begin
    txd       = 1'b1;
    uart_busy = (state != IDLE);
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shift[0];
      default: txd = 1'b1;
    endcase
  end

endmodule
